// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared helpers for the FIFO family: width derivation for pointers and
//   occupancy counters, and a parameter legality check used by every variant.
package fifo_pkg;

    // Pointer width for a DEPTH-entry buffer.
    function automatic int unsigned fifo_addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy counter width: one extra bit so DEPTH itself is representable.
    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // DEPTH must be a power of two >= 2 so pointers wrap by natural overflow.
    function automatic bit fifo_params_ok(input int unsigned width,
                                          input int unsigned depth,
                                          input int unsigned af_level,
                                          input int unsigned ae_level);
        bit ok;
        ok = 1'b1;
        if (width < 1)                          ok = 1'b0;
        if (depth < 2)                          ok = 1'b0;
        if ((depth & (depth - 1)) != 0)         ok = 1'b0;
        if (af_level < 1 || af_level > depth)   ok = 1'b0;
        if (ae_level > depth - 1)               ok = 1'b0;
        return ok;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_dpram.sv
// fifo_dpram
//   WIDTH x DEPTH storage, one synchronous write port and one synchronous
//   read port. No reset on contents or read register.
//   clk                 : clock, rising edge
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr       : read request; rd_data updates on the next edge
//   rd_data             : registered read data, holds while rd_en is low
module fifo_dpram #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Same-address read and write in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule : fifo_dpram

// File: rtl/param_circular_fifo.sv
// param_circular_fifo
//   Single-clock circular FIFO with generic width/depth, simultaneous read and
//   write, explicit occupancy counter, threshold flags, sticky error flags and
//   synchronous flush.
//   Clk, Rst_n          : clock (rising edge), async active-low reset
//   EN                  : global enable; low freezes all state, VALID low
//   Flush               : synchronous clear (pointers, Count, OVF/UDF, VALID)
//   WR, dataIn          : write request and data
//   RD                  : read request
//   dataOut, VALID      : registered read data, one-cycle pulse per read
//   Count               : occupancy 0..DEPTH
//   EMPTY/FULL/ALMOST_* : flags decoded from Count
//   OVF/UDF             : sticky overflow / underflow
module param_circular_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic                            EN,
    input  logic                            Flush,
    input  logic                            WR,
    input  logic [WIDTH-1:0]                dataIn,
    input  logic                            RD,
    output logic [WIDTH-1:0]                dataOut,
    output logic                            VALID,
    output logic [$clog2(DEPTH):0]          Count,
    output logic                            EMPTY,
    output logic                            FULL,
    output logic                            ALMOST_EMPTY,
    output logic                            ALMOST_FULL,
    output logic                            OVF,
    output logic                            UDF
);

    localparam int unsigned ADDR_W = fifo_addr_w(DEPTH);
    localparam int unsigned CNT_W  = fifo_cnt_w(DEPTH);

    generate
        if (!fifo_params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
            $error("param_circular_fifo: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL");
        end
    endgenerate

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              valid_q,  valid_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;
    logic              loaded_q, loaded_d;

    logic              empty, full;
    logic              rd_ok, wr_ok;
    logic              ram_we, ram_re;
    logic [WIDTH-1:0]  ram_rd_data;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // A write into a full FIFO is legal only when a read frees a slot.
    assign rd_ok = RD & ~empty;
    assign wr_ok = WR & (~full | rd_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        loaded_d = loaded_q;
        valid_d  = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;

        if (EN) begin
            if (Flush) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                count_d  = '0;
                ovf_d    = 1'b0;
                udf_d    = 1'b0;
            end else begin
                if (rd_ok) begin
                    ram_re   = 1'b1;
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    valid_d  = 1'b1;
                    loaded_d = 1'b1;
                end
                if (wr_ok) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                end
                if (wr_ok && !rd_ok) count_d = count_q + CNT_W'(1);
                if (rd_ok && !wr_ok) count_d = count_q - CNT_W'(1);
                if (WR && !wr_ok)    ovf_d   = 1'b1;
                if (RD && !rd_ok)    udf_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            loaded_q <= loaded_d;
        end
    end

    fifo_dpram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (Clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (dataIn),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // The RAM read register has no reset; dataOut reads as zero from reset
    // until the first accepted read loads it, and holds afterwards because
    // the RAM only updates its read register on an accepted read.
    assign dataOut      = loaded_q ? ram_rd_data : '0;
    assign VALID        = valid_q;
    assign Count        = count_q;
    assign EMPTY        = empty;
    assign FULL         = full;
    assign ALMOST_EMPTY = (count_q <= CNT_W'(AE_LEVEL));
    assign ALMOST_FULL  = (count_q >= CNT_W'(AF_LEVEL));
    assign OVF          = ovf_q;
    assign UDF          = udf_q;

endmodule : param_circular_fifo

// File: tb/tb_param_circular_fifo.sv
// tb_param_circular_fifo
//   Directed-vector bench for param_circular_fifo at WIDTH=32, DEPTH=8,
//   AF_LEVEL=6, AE_LEVEL=2. Inputs change 1 ns after the rising edge and
//   outputs are checked there, so each check sees the result of that edge.
module tb_param_circular_fifo;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        EN, Flush, WR, RD;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        VALID;
    logic [3:0]  Count;
    logic        EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, OVF, UDF;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    param_circular_fifo #(
        .WIDTH    (32),
        .DEPTH    (8),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .EN           (EN),
        .Flush        (Flush),
        .WR           (WR),
        .dataIn       (dataIn),
        .RD           (RD),
        .dataOut      (dataOut),
        .VALID        (VALID),
        .Count        (Count),
        .EMPTY        (EMPTY),
        .FULL         (FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .OVF          (OVF),
        .UDF          (UDF)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        WR = 1'b0; RD = 1'b0; Flush = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        WR = 1'b1; RD = 1'b0; dataIn = d;
        tick();
        idle();
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        WR = 1'b0; RD = 1'b1;
        tick();
        chk({tag, "_valid"}, 32'(VALID), 32'd1);
        chk({tag, "_data"},  dataOut,    exp);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0; EN = 1'b1; dataIn = '0;
        idle();
        #12;
        // Reset values
        chk("rst_count",  32'(Count),        32'd0);
        chk("rst_empty",  32'(EMPTY),        32'd1);
        chk("rst_full",   32'(FULL),         32'd0);
        chk("rst_ae",     32'(ALMOST_EMPTY), 32'd1);
        chk("rst_af",     32'(ALMOST_FULL),  32'd0);
        chk("rst_valid",  32'(VALID),        32'd0);
        chk("rst_dout",   dataOut,           32'd0);
        chk("rst_flags",  32'({OVF, UDF}),   32'd0);
        Rst_n = 1'b1;
        tick();

        // 1. Fill 0..7, then drain in order
        for (int i = 0; i < 8; i++) begin
            push(32'(i));
            chk("t1_wcount", 32'(Count),       32'(i + 1));
            chk("t1_af",     32'(ALMOST_FULL), (i + 1 >= 6) ? 32'd1 : 32'd0);
            chk("t1_ae",     32'(ALMOST_EMPTY),(i + 1 <= 2) ? 32'd1 : 32'd0);
        end
        chk("t1_full", 32'(FULL), 32'd1);
        for (int i = 0; i < 8; i++) begin
            pop_chk("t1_rd", 32'(i));
            chk("t1_rcount", 32'(Count), 32'(7 - i));
        end
        tick();
        chk("t1_valid_drop", 32'(VALID), 32'd0);
        chk("t1_empty",      32'(EMPTY), 32'd1);
        chk("t1_udf",        32'(UDF),   32'd0);

        // 2. Pointer wrap
        for (int i = 0; i < 5; i++) push(32'h10 + 32'(i));
        for (int i = 0; i < 5; i++) pop_chk("t2_a", 32'h10 + 32'(i));
        for (int i = 0; i < 6; i++) push(32'hA0 + 32'(i));
        chk("t2_count6", 32'(Count), 32'd6);
        for (int i = 0; i < 6; i++) pop_chk("t2_b", 32'hA0 + 32'(i));
        chk("t2_count0", 32'(Count), 32'd0);

        // 3. Full with simultaneous read and write
        for (int i = 0; i < 8; i++) push(32'h30 + 32'(i));
        WR = 1'b1; RD = 1'b1; dataIn = 32'hBEEF;
        tick();
        idle();
        chk("t3_dout",  dataOut,      32'h30);
        chk("t3_valid", 32'(VALID),   32'd1);
        chk("t3_count", 32'(Count),   32'd8);
        chk("t3_ovf",   32'(OVF),     32'd0);
        for (int i = 1; i < 8; i++) pop_chk("t3_rd", 32'h30 + 32'(i));
        pop_chk("t3_last", 32'hBEEF);
        chk("t3_empty", 32'(EMPTY), 32'd1);

        // 4. Overflow and underflow
        for (int i = 0; i < 8; i++) push(32'h40 + 32'(i));
        push(32'h99);
        chk("t4_count_ovf", 32'(Count), 32'd8);
        chk("t4_ovf",       32'(OVF),   32'd1);
        tick();
        chk("t4_ovf_sticky", 32'(OVF), 32'd1);
        for (int i = 0; i < 8; i++) pop_chk("t4_rd", 32'h40 + 32'(i));
        WR = 1'b1; RD = 1'b1; dataIn = 32'h55;
        tick();
        idle();
        chk("t4_udf",       32'(UDF),   32'd1);
        chk("t4_valid",     32'(VALID), 32'd0);
        chk("t4_count_udf", 32'(Count), 32'd1);
        chk("t4_dout_hold", dataOut,    32'h47);

        // 5. Flush overrides RD/WR
        push(32'h56); push(32'h57); push(32'h58);
        chk("t5_count4", 32'(Count), 32'd4);
        Flush = 1'b1; WR = 1'b1; RD = 1'b1; dataIn = 32'h77;
        tick();
        idle();
        chk("t5_count", 32'(Count),      32'd0);
        chk("t5_empty", 32'(EMPTY),      32'd1);
        chk("t5_flags", 32'({OVF, UDF}), 32'd0);
        chk("t5_valid", 32'(VALID),      32'd0);
        chk("t5_dout",  dataOut,         32'h47);

        // 6. EN=0 freezes state, then async reset mid-read
        push(32'h60); push(32'h61);
        EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            WR = 1'b1; RD = 1'b1; Flush = i[0]; dataIn = 32'hDEAD;
            tick();
            chk("t6_count", 32'(Count),      32'd2);
            chk("t6_valid", 32'(VALID),      32'd0);
            chk("t6_dout",  dataOut,         32'h47);
            chk("t6_flags", 32'({OVF, UDF}), 32'd0);
        end
        idle();
        EN = 1'b1;
        pop_chk("t6_rd", 32'h60);
        chk("t6_count1", 32'(Count), 32'd1);
        RD = 1'b1;
        Rst_n = 1'b0;
        #2;
        chk("t6_rst_valid", 32'(VALID), 32'd0);
        chk("t6_rst_dout",  dataOut,    32'd0);
        chk("t6_rst_count", 32'(Count), 32'd0);
        chk("t6_rst_empty", 32'(EMPTY), 32'd1);
        chk("t6_rst_ae",    32'(ALMOST_EMPTY), 32'd1);
        idle();
        #3;
        Rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_param_circular_fifo
